regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Arbitrates the register file's single write port between two writeback requesters: the ALU result path and the memory (load) result path. Each requester uses a valid/ready handshake. The block registers the winning write and drives `Reg_Write`/`rd`/`Write_Data` of `registerFile` one cycle later. Memory writeback has fixed priority, bounded by an anti-starvation counter for the ALU.

## Interface
Parameters:
- `DATA_W`, 64, writeback data width; matches the register file.
- `MAX_WAIT`, 3, consecutive cycles the ALU may be refused before it takes priority; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; asserted when 0.
- `alu_valid`  in  1  ALU requester has a write pending.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  DATA_W  ALU write value.
- `alu_ready`  out  1  ALU write accepted this cycle when `alu_valid` is also 1.
- `mem_valid`  in  1  memory requester has a write pending.
- `mem_rd`  in  5  memory destination register.
- `mem_data`  in  DATA_W  memory write value.
- `mem_ready`  out  1  memory write accepted this cycle when `mem_valid` is also 1.
- `Reg_Write`  out  1  write enable to the register file.
- `rd`  out  5  write address to the register file.
- `Write_Data`  out  DATA_W  write data to the register file.
- `alu_starved`  out  1  high while `wait_cnt == MAX_WAIT`.

## Operation
- Internal state:
  - `wait_cnt`, 4 bits, saturating.
  - Output register {`Reg_Write`, `rd`, `Write_Data`}.
- Priority rule (`boost = alu_valid && wait_cnt == MAX_WAIT`):
  - `mem_ready = !boost`.
  - `alu_ready = !mem_valid || boost`.
  - Ready signals are combinational; each may be high while its own valid is low.
- Handshake: a transfer occurs on a requester when valid && ready in the same cycle. At most one transfer per cycle.
- Output register update on each clock edge:
  - Memory transfer: `Reg_Write <= (mem_rd != 0)`, `rd <= mem_rd`, `Write_Data <= mem_data`.
  - ALU transfer: same rule using `alu_rd` and `alu_data`.
  - No transfer: `Reg_Write <= 0`; `rd` and `Write_Data` hold their previous values.
- Writes to x0 complete the handshake normally but never assert `Reg_Write`.
- `wait_cnt` update:
  - Clears on an ALU transfer, or when `alu_valid` = 0.
  - Otherwise (ALU valid and refused), increments, saturating at `MAX_WAIT`.
- When both requesters target the same `rd` in the same cycle, the winner writes first and the loser writes in a later cycle. The register ends holding the loser's value. Requesters own ordering.
- Requesters must hold `*_rd` and `*_data` stable while valid && !ready. Behaviour is undefined otherwise.

## Timing
- Reset values (reset = 0, asynchronous):
  - `Reg_Write` = 0, `rd` = 0, `Write_Data` = 0.
  - `wait_cnt` = 0, `alu_starved` = 0.
- While reset is asserted, `alu_ready` and `mem_ready` are forced to 0.
- Latency: a transfer in cycle N drives `Reg_Write` = 1 (nonzero rd) during cycle N+1 only. The register file captures it on the edge ending N+1.
- Throughput: one write per cycle, back-to-back.
- Reset asserted mid-operation: a write held in the output register is discarded, and `Reg_Write` drops immediately (asynchronously). Nothing is replayed after reset.
- Worst-case ALU wait under continuous memory traffic: exactly `MAX_WAIT` refused cycles, then a guaranteed grant on the next cycle.
- Reset release: the first transfer is possible in the first cycle after `reset` returns to 1.

## Test plan
- Reset check: hold reset = 0 with both valids = 1 → both readies = 0, `Reg_Write` = 0, `rd` = 0, `Write_Data` = 0. Release → `mem_ready` = 1 on the first cycle.
- Single ALU write: `alu_valid` = 1, `alu_rd` = 5, `alu_data` = 0xDEAD, memory idle → `alu_ready` = 1 in cycle N. Cycle N+1 shows `Reg_Write` = 1, `rd` = 5, `Write_Data` = 0xDEAD. Cycle N+2 shows `Reg_Write` = 0.
- Contention: both valid every cycle, `MAX_WAIT` = 3 → memory granted 3 cycles, then the ALU is granted on the 4th with `alu_starved` = 1 that cycle. `wait_cnt` returns to 0 and the pattern repeats 3:1.
- x0 drop: `mem_valid` = 1, `mem_rd` = 0, `mem_data` = 0xFF → `mem_ready` = 1, next cycle `Reg_Write` = 0. Register 0 is still 0 when read back through `registerFile`.
- Same-rd collision: ALU and memory both target rd 7 with 0x11 and 0x22, memory wins first → `Write_Data` sequence is 0x22 then 0x11. `registerFile` reads 0x11 afterwards.
- Reset mid-write: assert reset in the cycle where `Reg_Write` = 1 → `Reg_Write` falls within that cycle with no clock edge. The target register keeps its old value.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the register file's single write port between the ALU writeback
// path and the memory (load) writeback path. Memory has fixed priority, but
// an ALU request that has been refused MAX_WAIT consecutive cycles takes
// priority on the next cycle. The winning write is registered and presented
// to the register file one cycle after the handshake.
//
// Handshake: a requester transfers in a cycle where its valid and ready are
// both high. Ready is combinational and may be high while valid is low. A
// requester holding valid with ready low must keep rd/data stable. At most
// one transfer happens per cycle. Both readies are low while reset is held.
module regfile_write_arbiter #(
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [4:0]        alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [4:0]        mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              Reg_Write,
    output logic [4:0]        rd,
    output logic [DATA_W-1:0] Write_Data,
    output logic              alu_starved
);

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    logic [3:0]        r_wait_cnt;
    logic              r_reg_write;
    logic [4:0]        r_rd;
    logic [DATA_W-1:0] r_write_data;

    logic              w_boost;
    logic              w_mem_xfer;
    logic              w_alu_xfer;

    // Priority decision: memory wins unless the ALU has hit its wait limit.
    always_comb begin
        w_boost    = alu_valid && (r_wait_cnt == LP_MAX_WAIT);
        mem_ready  = reset && !w_boost;
        alu_ready  = reset && (!mem_valid || w_boost);
        w_mem_xfer = mem_valid && mem_ready;
        w_alu_xfer = alu_valid && alu_ready;
    end

    // Output register: capture the winning write; x0 completes but never enables.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_reg_write  <= 1'b0;
            r_rd         <= 5'd0;
            r_write_data <= '0;
        end else if (w_mem_xfer) begin
            r_reg_write  <= (mem_rd != 5'd0);
            r_rd         <= mem_rd;
            r_write_data <= mem_data;
        end else if (w_alu_xfer) begin
            r_reg_write  <= (alu_rd != 5'd0);
            r_rd         <= alu_rd;
            r_write_data <= alu_data;
        end else begin
            r_reg_write  <= 1'b0;
        end
    end

    // Anti-starvation counter: counts consecutive refused ALU cycles, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= 4'd0;
        end else if (!alu_valid || w_alu_xfer) begin
            r_wait_cnt <= 4'd0;
        end else if (r_wait_cnt != LP_MAX_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    assign Reg_Write   = r_reg_write;
    assign rd          = r_rd;
    assign Write_Data  = r_write_data;
    assign alu_starved = (r_wait_cnt == LP_MAX_WAIT);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vectors, a cycle-level reference
// model of the arbitration rules and a register-file image, and a negedge
// compare process, plus literal spot checks.
module tb_regfile_write_arbiter;

  localparam int DATA_W   = 64;
  localparam int MAX_WAIT = 3;

  logic              clk;
  logic              reset;
  logic              alu_valid;
  logic [4:0]        alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [4:0]        mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              Reg_Write;
  logic [4:0]        rd;
  logic [DATA_W-1:0] Write_Data;
  logic              alu_starved;

  int total = 0;
  int bad   = 0;

  regfile_write_arbiter #(.DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .mem_valid  (mem_valid),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .Reg_Write  (Reg_Write),
    .rd         (rd),
    .Write_Data (Write_Data),
    .alu_starved(alu_starved)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // refused: consecutive cycles the ALU has been turned away (capped).
  int                refused = 0;
  logic              m_we    = 1'b0;
  logic [4:0]        m_rd    = 5'd0;
  logic [DATA_W-1:0] m_data  = '0;
  logic [DATA_W-1:0] rf [32];

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
  end

  // 0 = nobody, 1 = memory, 2 = ALU
  function automatic int winner(input logic av, input logic mv, input int ref_cnt);
    bit alu_overdue;
    alu_overdue = av && (ref_cnt == MAX_WAIT);
    if (mv && !alu_overdue) return 1;
    if (av) return 2;
    return 0;
  endfunction

  function automatic int next_refused(input logic av, input logic mv, input int ref_cnt);
    if (av && winner(av, mv, ref_cnt) != 2)
      return (ref_cnt + 1 > MAX_WAIT) ? MAX_WAIT : ref_cnt + 1;
    return 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_we    <= 1'b0;
      m_rd    <= 5'd0;
      m_data  <= '0;
      refused <= 0;
    end else begin
      if (m_we) rf[m_rd] <= m_data;
      refused <= next_refused(alu_valid, mem_valid, refused);
      case (winner(alu_valid, mem_valid, refused))
        1: begin m_we <= (mem_rd != 0); m_rd <= mem_rd; m_data <= mem_data; end
        2: begin m_we <= (alu_rd != 0); m_rd <= alu_rd; m_data <= alu_data; end
        default: m_we <= 1'b0;
      endcase
    end
  end

  // Compare process: every negedge, all outputs against the model.
  always @(negedge clk) begin
    int w;
    w = winner(alu_valid, mem_valid, refused);
    chk("cmp_mem_ready", {63'd0, mem_ready},
        {63'd0, reset && !(alu_valid && refused == MAX_WAIT)});
    chk("cmp_alu_ready", {63'd0, alu_ready},
        {63'd0, reset && (!mem_valid || (alu_valid && refused == MAX_WAIT))});
    chk("cmp_grant_alu", {63'd0, alu_valid && alu_ready}, {63'd0, reset && w == 2});
    chk("cmp_reg_write", {63'd0, Reg_Write}, {63'd0, m_we});
    chk("cmp_rd", {59'd0, rd}, {59'd0, m_rd});
    chk("cmp_write_data", Write_Data, m_data);
    chk("cmp_starved", {63'd0, alu_starved}, {63'd0, reset && refused == MAX_WAIT});
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [63:0] md);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = md;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] grant_pat;
  logic [7:0] starve_pat;

  initial begin
    reset = 1'b0;
    drive(1'b1, 5'd1, 64'h1, 1'b1, 5'd3, 64'h33);
    tick();
    tick();

    // Reset held with both valids: readies forced low, outputs zero.
    #2;
    chk("rst_alu_ready", {63'd0, alu_ready}, 64'd0);
    chk("rst_mem_ready", {63'd0, mem_ready}, 64'd0);
    chk("rst_reg_write", {63'd0, Reg_Write}, 64'd0);
    chk("rst_rd", {59'd0, rd}, 64'd0);
    chk("rst_write_data", Write_Data, 64'd0);

    // Release: memory accepted in the very first cycle.
    #1 reset = 1'b1;
    #2;
    chk("rel_mem_ready", {63'd0, mem_ready}, 64'd1);
    chk("rel_alu_ready", {63'd0, alu_ready}, 64'd0);
    tick();
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    #2;
    chk("rel_we", {63'd0, Reg_Write}, 64'd1);
    chk("rel_rd", {59'd0, rd}, 64'd3);
    chk("rel_wd", Write_Data, 64'h33);
    tick();

    // Single ALU write.
    drive(1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0, 64'h0);
    #2;
    chk("alu_ready_idle_mem", {63'd0, alu_ready}, 64'd1);
    tick();
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    #2;
    chk("alu_we", {63'd0, Reg_Write}, 64'd1);
    chk("alu_rd", {59'd0, rd}, 64'd5);
    chk("alu_wd", Write_Data, 64'hDEAD);
    tick();
    #2;
    chk("alu_we_drop", {63'd0, Reg_Write}, 64'd0);
    chk("alu_rd_hold", {59'd0, rd}, 64'd5);
    tick();

    // Contention: both valid for 8 cycles -> 3 memory grants then 1 ALU, repeating.
    grant_pat  = '0;
    starve_pat = '0;
    drive(1'b1, 5'd10, 64'hA0A0, 1'b1, 5'd11, 64'hB0B0);
    for (int i = 0; i < 8; i++) begin
      #2;
      grant_pat[i]  = alu_valid && alu_ready;
      starve_pat[i] = alu_starved;
      tick();
    end
    chk("cont_grant_pattern", {56'd0, grant_pat}, 64'h88);
    chk("cont_starve_pattern", {56'd0, starve_pat}, 64'h88);
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    tick();

    // x0 drop.
    drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd0, 64'hFF);
    #2;
    chk("x0_mem_ready", {63'd0, mem_ready}, 64'd1);
    tick();
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    #2;
    chk("x0_we", {63'd0, Reg_Write}, 64'd0);
    chk("x0_rd", {59'd0, rd}, 64'd0);
    tick();
    chk("x0_rf0", rf[0], 64'd0);

    // Same-rd collision: memory first, ALU second, register ends with ALU value.
    drive(1'b1, 5'd7, 64'h11, 1'b1, 5'd7, 64'h22);
    #2;
    chk("col_mem_ready", {63'd0, mem_ready}, 64'd1);
    chk("col_alu_ready", {63'd0, alu_ready}, 64'd0);
    tick();
    drive(1'b1, 5'd7, 64'h11, 1'b0, 5'd0, 64'h0);
    #2;
    chk("col_first_wd", Write_Data, 64'h22);
    chk("col_alu_ready2", {63'd0, alu_ready}, 64'd1);
    tick();
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    #2;
    chk("col_second_wd", Write_Data, 64'h11);
    chk("col_second_we", {63'd0, Reg_Write}, 64'd1);
    tick();
    chk("col_rf7", rf[7], 64'h11);

    // Reset mid-write: Reg_Write drops without a clock edge, target keeps old value.
    drive(1'b1, 5'd9, 64'h99, 1'b0, 5'd0, 64'h0);
    tick();
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    #1;
    chk("mid_we_before", {63'd0, Reg_Write}, 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_we_async_drop", {63'd0, Reg_Write}, 64'd0);
    chk("mid_rd_async", {59'd0, rd}, 64'd0);
    tick();
    #2 reset = 1'b1;
    tick();
    tick();
    chk("mid_rf9", rf[9], 64'd0);
    chk("mid_no_replay", {63'd0, Reg_Write}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
